// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    // Slot index: which digit position is being driven this refresh slot.
    typedef enum logic [1:0] {
        SLOT_SEC_LOW  = 2'd0,
        SLOT_SEC_HIGH = 2'd1,
        SLOT_MIN_LOW  = 2'd2,
        SLOT_MIN_HIGH = 2'd3
    } slot_t;

    // Segment patterns, {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seg_decoder.sv
// BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Straight table lookup; anything above 9 is an invalid BCD digit.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a four-digit mm:ss seven-segment display.
// Digits are snapshotted once per frame so a frame never mixes old and new time.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sec_low,
    input  logic [3:0] sec_high,
    input  logic [3:0] min_low,
    input  logic [3:0] min_high,
    input  logic       blank_lead,
    input  logic       dp_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESCALE_TOP = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DEAD_END     = PW'(DEAD_CYC);

    logic [PW-1:0] prescale;
    slot_t         slot;
    logic [3:0]    snap [NUM_DIGITS];
    logic          tick;
    logic          lit;
    logic [3:0]    cur_digit;
    logic [6:0]    cur_seg;
    logic [3:0]    an_next;
    logic          dp_next;

    assign tick        = (prescale == PRESCALE_TOP);
    assign frame_start = tick && (slot == SLOT_MIN_HIGH);

    // Prescaler and slot index: slot advances once per full prescaler period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            slot     <= SLOT_SEC_LOW;
        end else if (tick) begin
            prescale <= '0;
            slot     <= slot_t'(slot + 2'd1);
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // Snapshot all four digits at the end of the last slot of each frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap[i] <= 4'd0;
            end
        end else if (frame_start) begin
            snap[0] <= sec_low;
            snap[1] <= sec_high;
            snap[2] <= min_low;
            snap[3] <= min_high;
        end
    end

    // Pick the snapshot digit and anode/dp pattern for the current slot.
    always_comb begin
        cur_digit = snap[0];
        case (slot)
            SLOT_SEC_LOW:  cur_digit = snap[0];
            SLOT_SEC_HIGH: cur_digit = snap[1];
            SLOT_MIN_LOW:  cur_digit = snap[2];
            SLOT_MIN_HIGH: cur_digit = snap[3];
            default:       cur_digit = snap[0];
        endcase
        lit = (prescale >= DEAD_END) &&
              !((slot == SLOT_MIN_HIGH) && blank_lead && (snap[3] == 4'd0));
        an_next = 4'b1111;
        if (lit) begin
            an_next[slot] = 1'b0;
        end
        dp_next = !(lit && (slot == SLOT_MIN_LOW) && dp_en);
    end

    seg_decoder u_seg_decoder (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    // Register the display outputs so the pins see clean, glitch-free levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= cur_seg;
            dp  <= dp_next;
        end
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-002 The block SHALL have parameter DEAD_CYC, default 500: cycles per slot with all anodes off (ghost suppression); 0 < DEAD_CYC < REFRESH_DIV.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port sec_low, input, 4 bits: BCD seconds units, from the mod-60 counter.
REQ-006 The block SHALL have port sec_high, input, 4 bits: BCD seconds tens.
REQ-007 The block SHALL have port min_low, input, 4 bits: BCD minutes units.
REQ-008 The block SHALL have port min_high, input, 4 bits: BCD minutes tens.
REQ-009 The block SHALL have port blank_lead, input, 1 bit: suppress the min_high digit when it is 0.
REQ-010 The block SHALL have port dp_en, input, 1 bit: light the decimal point on slot 2 (minutes/seconds separator).
REQ-011 The block SHALL have port seg, output, 7 bits: {g,f,e,d,c,b,a}, active-low.
REQ-012 The block SHALL have port dp, output, 1 bit: decimal point, active-low.
REQ-013 The block SHALL have port an, output, 4 bits: digit anodes, active-low; an[i] selects slot i.
REQ-014 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse when a new snapshot is taken.

Function
REQ-015 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; a tick SHALL occur in the cycle it holds REFRESH_DIV-1.
REQ-016 A 2-bit slot index SHALL advance on each tick and wrap 3->0. Slot 0=sec_low, 1=sec_high, 2=min_low, 3=min_high.
REQ-017 On the tick where the index wraps 3->0, the block SHALL capture all four digit inputs into snapshot registers and pulse frame_start for exactly that cycle.
REQ-018 The block SHALL drive displayed data only from snapshots, never directly from the inputs; an input change mid-frame SHALL NOT appear until the next frame.
REQ-019 an SHALL be 4'b1111 while prescaler < DEAD_CYC; otherwise only an[index] SHALL be 0.
REQ-020 BCD decode SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10..15 SHALL show dash 0111111.
REQ-021 For slot 3, when blank_lead=1 and the min_high snapshot is 0, an[3] SHALL remain 1 for the whole slot.
REQ-022 dp SHALL be 0 only when index=2, dp_en=1 and an[2]=0; otherwise it SHALL be 1.
REQ-023 seg, dp and an SHALL be registered, with exactly one cycle of latency from the internal prescaler and index state; no combinational path from input to output.
REQ-024 Before the first snapshot after reset, the snapshots SHALL hold 0.

Reset
REQ-025 While reset=1, the block SHALL hold: prescaler=0, index=0, all snapshots=0, an=1111, seg=1111111, dp=1, frame_start=0.
REQ-026 A reset asserted mid-slot or mid-frame SHALL take effect immediately and asynchronously, and SHALL discard the partial frame.
REQ-027 After reset deasserts, scanning SHALL restart at slot 0, prescaler 0.

Structure
REQ-028 Package seven_seg_pkg SHALL hold the segment-code constants, the dash code, NUM_DIGITS=4 and the slot index type.
REQ-029 Sub-module seg_decoder (combinational, 4-bit BCD in, 7-bit active-low out) SHALL implement REQ-020.

Verification (REFRESH_DIV=4, DEAD_CYC=1)
REQ-030 The bench SHALL check: hold reset -> an=1111, seg=1111111, dp=1, frame_start=0 throughout.
REQ-031 The bench SHALL check: release reset with inputs 0 -> an sequence repeats with period 16: 1111x1, 1110x3, 1111x1, 1101x3, 1111x1, 1011x3, 1111x1, 0111x3; seg=1000000 during lit cycles.
REQ-032 The bench SHALL check: inputs 5,4,3,2 (sec_low..min_high), first frame_start -> next frame shows slot0 0010010, slot1 0011001, slot2 0110000, slot3 0100100; frame_start period = 16 cycles.
REQ-033 The bench SHALL check: change sec_low 5->7 during slot 1 -> slot 0 still shows 5 in the remainder of that frame and shows 7 (1111000) only after the next frame_start.
REQ-034 The bench SHALL check: min_high=0 with blank_lead=1, dp_en=1 -> an[3] never 0; dp=0 only during lit slot-2 cycles. Then min_high=12 with blank_lead=0 -> slot 3 shows 0111111.
REQ-035 The bench SHALL check: assert reset during slot 2 -> outputs reach reset values without waiting for a clock edge; after release, the scan restarts at an=1111 then 1110.
